// File: rtl/bit_serial_maj_adder.sv
// Bit-serial LSB-first adder driving a single majority-gate full-adder cell.
// Optional signed-overflow output enabled by defining BSA_OVERFLOW_EN.
module bit_serial_maj_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef BSA_OVERFLOW_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    function automatic logic maj(input logic p, input logic q, input logic r);
        return (p & q) | (p & r) | (q & r);
    endfunction

    // Full adder from majority gates and inverters only.
    logic x, y, co, s;
    assign x  = a_sh[0];
    assign y  = b_sh[0];
    assign co = maj(x, y, carry);
    assign s  = maj(~co, carry, maj(x, y, ~carry));

    assign sum  = sum_sh;
    assign cout = carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
`ifdef BSA_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    sum_sh <= {s, sum_sh[WIDTH-1:1]};
                    carry  <= co;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
`ifdef BSA_OVERFLOW_EN
                        ovf       <= carry ^ co;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
